uart_tx_param: RTL and testbench



---
 rtl/uart_tx_param_if.sv | 24 ++
 rtl/uart_tx_param.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_param_if.sv
// Host-side port bundle for uart_tx_param: write strobe, data, enable and baud select in,
// serial line and status out.
interface uart_tx_param_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] Tx_DATA;
    logic                 Tx_WR;
    logic                 Tx_EN;
    logic [2:0]           baud_select;
    logic                 TxD;
    logic                 Tx_BUSY;
    logic                 Tx_FULL;
    logic                 Tx_DONE;

    modport master (
        output Tx_DATA, Tx_WR, Tx_EN, baud_select,
        input  TxD, Tx_BUSY, Tx_FULL, Tx_DONE
    );

    modport slave (
        input  Tx_DATA, Tx_WR, Tx_EN, baud_select,
        output TxD, Tx_BUSY, Tx_FULL, Tx_DONE
    );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with 16x-oversampled baud divider, parity and 1/2 stop bits.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry write queue; otherwise a single holding slot.
module uart_tx_param #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 1,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned LSB_FIRST   = 0,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input logic             clk,
    input logic             reset,
    uart_tx_param_if.slave  host_io
);

    localparam int unsigned DivMax = (CLK_HZ + 2400) / 4800;
    localparam int unsigned DivW   = $clog2(DivMax + 1);

    // Out-of-range parameters keep the transmitter parked in idle.
    localparam bit ParamsOk = (DATA_BITS >= 5) && (DATA_BITS <= 9) && (PARITY_MODE <= 2) &&
                              (STOP_BITS >= 1) && (STOP_BITS <= 2) && (FIFO_DEPTH >= 2) &&
                              ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    function automatic logic [DivW-1:0] div_for(input logic [2:0] sel);
        int unsigned baud;
        int unsigned d;
        case (sel)
            3'd0:    baud = 300;
            3'd1:    baud = 1200;
            3'd2:    baud = 4800;
            3'd3:    baud = 9600;
            3'd4:    baud = 19200;
            3'd5:    baud = 38400;
            3'd6:    baud = 57600;
            default: baud = 115200;
        endcase
        d = (CLK_HZ + 8 * baud) / (16 * baud);
        if (d == 0) begin
            d = 1;
        end
        return DivW'(d);
    endfunction

    function automatic logic first_bit(input logic [DATA_BITS-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[DATA_BITS-1];
    endfunction

    function automatic logic [DATA_BITS-1:0] shift_out(input logic [DATA_BITS-1:0] w);
        return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
    endfunction

    state_e               state_q;
    logic                 txd_q;
    logic                 done_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic [DivW-1:0]      div_q;
    logic [DivW-1:0]      div_cnt_q;
    logic [3:0]           tick_cnt_q;
    logic [3:0]           bit_cnt_q;
    logic                 stop_cnt_q;

    logic                 active;
    logic                 avail;
    logic                 busy;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 tick;
    logic                 bit_end;
    logic                 stop_end;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    assign active   = state_q inside {StStart, StData, StParity, StStop};
    assign busy     = active || avail;
    assign tick     = (div_cnt_q == div_q - DivW'(1));
    assign bit_end  = tick && (tick_cnt_q == 4'd15);
    assign stop_end = (state_q == StStop) && bit_end && (stop_cnt_q == 1'(STOP_BITS - 1));
    assign head_par = (PARITY_MODE == 2) ? ~(^head) : (^head);

    assign push = host_io.Tx_WR && host_io.Tx_EN && !full;
    assign pop  = ParamsOk && avail && host_io.Tx_EN && (!active || stop_end);

`ifdef UART_TX_FIFO_EN
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AddrW-1:0]     wr_ptr_q;
    logic [AddrW-1:0]     rd_ptr_q;
    logic [AddrW:0]       count_q;

    assign avail = (count_q != '0);
    assign head  = mem_q[rd_ptr_q];
    // full gates push, so a write while full is dropped even when a pop frees a slot.
    assign full  = (count_q == (AddrW + 1)'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= host_io.Tx_DATA;
                wr_ptr_q        <= wr_ptr_q + AddrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AddrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AddrW + 1)'(1);
                2'b01:   count_q <= count_q - (AddrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
`else
    logic                 hold_valid_q;
    logic [DATA_BITS-1:0] hold_q;

    assign avail = hold_valid_q;
    assign head  = hold_q;
    assign full  = busy;

    // push needs !busy and pop needs a held word, so they never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
        end else if (push) begin
            hold_valid_q <= 1'b1;
            hold_q       <= host_io.Tx_DATA;
        end else if (pop) begin
            hold_valid_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            div_q      <= div_for(3'd7);
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (active) begin
                div_cnt_q <= tick ? '0 : div_cnt_q + DivW'(1);
                if (tick) begin
                    tick_cnt_q <= tick_cnt_q + 4'd1;
                end
            end
            case (state_q)
                StStart: begin
                    if (bit_end) begin
                        state_q   <= StData;
                        txd_q     <= first_bit(shift_q);
                        shift_q   <= shift_out(shift_q);
                        bit_cnt_q <= '0;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                            if (PARITY_MODE != 0) begin
                                state_q <= StParity;
                                txd_q   <= par_q;
                            end else begin
                                state_q    <= StStop;
                                txd_q      <= 1'b1;
                                stop_cnt_q <= 1'b0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            txd_q     <= first_bit(shift_q);
                            shift_q   <= shift_out(shift_q);
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state_q    <= StStop;
                        txd_q      <= 1'b1;
                        stop_cnt_q <= 1'b0;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        if (stop_end) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                            txd_q   <= 1'b1;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    txd_q   <= 1'b1;
                end
            endcase
            // A pop overrides the above, giving back-to-back frames after the last stop bit.
            if (pop) begin
                state_q    <= StStart;
                txd_q      <= 1'b0;
                shift_q    <= head;
                par_q      <= head_par;
                div_q      <= div_for(host_io.baud_select);
                div_cnt_q  <= '0;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
                stop_cnt_q <= 1'b0;
            end
        end
    end

    assign host_io.TxD     = txd_q;
    assign host_io.Tx_BUSY = busy;
    assign host_io.Tx_FULL = full;
    assign host_io.Tx_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: two instances (8E1 MSB-first, 7O2 LSB-first) at 50 MHz.
// Queue-specific expectations follow UART_TX_FIFO_EN.
module tb_uart_tx_param;

    localparam int BitA  = 432;   // 115200 baud: DIV 27
    localparam int BitB6 = 864;   // 57600 baud: DIV 54
    localparam int Frame = 11 * BitA;

    // Line sequences, bit i = i-th bit on the wire (start first).
    localparam logic [10:0] SeqA5  = 11'b10101001010;
    localparam logic [10:0] Seq00  = 11'b10000000000;
    localparam logic [10:0] SeqFF  = 11'b10111111110;
    localparam logic [10:0] Seq01  = 11'b11100000000;
    localparam logic [10:0] Seq80  = 11'b11000000010;
    localparam logic [10:0] SeqB41 = 11'b11110000010;

`ifdef UART_TX_FIFO_EN
    localparam int ExpDoneA = 9;
`else
    localparam int ExpDoneA = 2;
`endif

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_a = 0;
    int   done_b = 0;
    int   s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus_a.Tx_DONE) done_a <= done_a + 1;
        if (bus_b.Tx_DONE) done_b <= done_b + 1;
    end

    uart_tx_param_if #(.DATA_BITS(8)) bus_a ();
    uart_tx_param_if #(.DATA_BITS(7)) bus_b ();

    uart_tx_param #(
        .CLK_HZ      (50_000_000),
        .DATA_BITS   (8),
        .PARITY_MODE (1),
        .STOP_BITS   (1),
        .LSB_FIRST   (0),
        .FIFO_DEPTH  (4)
    ) dut_a (
        .clk     (clk),
        .reset   (reset),
        .host_io (bus_a.slave)
    );

    uart_tx_param #(
        .CLK_HZ      (50_000_000),
        .DATA_BITS   (7),
        .PARITY_MODE (2),
        .STOP_BITS   (2),
        .LSB_FIRST   (1),
        .FIFO_DEPTH  (4)
    ) dut_b (
        .clk     (clk),
        .reset   (reset),
        .host_io (bus_b.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] obs_txd(input int sel);
        return 32'((sel != 0) ? bus_b.TxD : bus_a.TxD);
    endfunction
    function automatic logic [31:0] obs_busy(input int sel);
        return 32'((sel != 0) ? bus_b.Tx_BUSY : bus_a.Tx_BUSY);
    endfunction
    function automatic logic [31:0] obs_full(input int sel);
        return 32'((sel != 0) ? bus_b.Tx_FULL : bus_a.Tx_FULL);
    endfunction
    function automatic logic [31:0] obs_done(input int sel);
        return 32'((sel != 0) ? bus_b.Tx_DONE : bus_a.Tx_DONE);
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic write_a(input logic [7:0] d);
        bus_a.Tx_DATA = d;
        bus_a.Tx_WR   = 1'b1;
        @(negedge clk);
        bus_a.Tx_WR   = 1'b0;
    endtask

    task automatic write_b(input logic [6:0] d);
        bus_b.Tx_DATA = d;
        bus_b.Tx_WR   = 1'b1;
        @(negedge clk);
        bus_b.Tx_WR   = 1'b0;
    endtask

    // Checks first and last cycle of each of 11 bits from start edge s, then the Tx_DONE pulse.
    task automatic walk(input int sel, input int st, input logic [10:0] bits, input int blen,
                        input int drop_bit, input string tag);
        int t0;
        for (int i = 0; i < 11; i++) begin
            t0 = st + i * blen;
            if (cyc <= t0) begin
                wait_until(t0);
                check_eq($sformatf("%s_b%0d_first", tag, i), obs_txd(sel), 32'(bits[i]));
            end
            if (i == drop_bit) bus_a.Tx_EN = 1'b0;
            wait_until(t0 + blen - 1);
            check_eq($sformatf("%s_b%0d_last", tag, i), obs_txd(sel), 32'(bits[i]));
        end
        check_eq({tag, "_done_early"}, obs_done(sel), 0);
        wait_until(st + 11 * blen);
        check_eq({tag, "_done"}, obs_done(sel), 1);
    endtask

`ifdef UART_TX_FIFO_EN
    logic [7:0]  words [6] = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h3C};
    logic [10:0] seqs  [5] = '{SeqA5, Seq00, SeqFF, Seq01, Seq80};
    int          exp_full [6] = '{0, 0, 0, 0, 1, 1};
`endif

    initial begin
        bus_a.Tx_DATA = '0; bus_a.Tx_WR = 1'b0; bus_a.Tx_EN = 1'b1; bus_a.baud_select = 3'd7;
        bus_b.Tx_DATA = '0; bus_b.Tx_WR = 1'b0; bus_b.Tx_EN = 1'b1; bus_b.baud_select = 3'd7;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_txd_a", obs_txd(0), 1);
        check_eq("rst_busy_a", obs_busy(0), 0);
        check_eq("rst_full_a", obs_full(0), 0);
        check_eq("rst_done_a", obs_done(0), 0);
        check_eq("rst_txd_b", obs_txd(1), 1);
        check_eq("rst_busy_b", obs_busy(1), 0);
        reset = 1'b0;
        @(negedge clk);

        // Single 8E1 frame, MSB first.
        write_a(8'hA5);
        s = cyc + 1;
        check_eq("a5_busy_rise", obs_busy(0), 1);
        check_eq("a5_txd_idle", obs_txd(0), 1);
`ifdef UART_TX_FIFO_EN
        check_eq("a5_full", obs_full(0), 0);
`else
        check_eq("a5_full_is_busy", obs_full(0), 1);
`endif
        walk(0, s, SeqA5, BitA, -1, "a5");
        check_eq("a5_busy_fall", obs_busy(0), 0);
        @(negedge clk);
        check_eq("a5_done_one_cycle", obs_done(0), 0);
        repeat (500) @(negedge clk);
        check_eq("a5_idle_after", obs_txd(0), 1);
        check_eq("a5_done_count", done_a, 1);

        // 7O2 LSB first at 57600; baud change mid-frame must not affect this frame.
        bus_b.baud_select = 3'd6;
        write_b(7'h41);
        s = cyc + 1;
        @(negedge clk);
        bus_b.baud_select = 3'd7;
        walk(1, s, SeqB41, BitB6, -1, "b41");
        check_eq("b41_busy_fall", obs_busy(1), 0);
        @(negedge clk);
        check_eq("b41_done_count", done_b, 1);

        // Write with Tx_EN low is dropped.
        bus_a.Tx_EN = 1'b0;
        write_a(8'h55);
        check_eq("en0_busy", obs_busy(0), 0);
        repeat (600) @(negedge clk);
        check_eq("en0_txd", obs_txd(0), 1);
        check_eq("en0_done_count", done_a, 1);
        bus_a.Tx_EN = 1'b1;

        // Three writes back to back; Tx_EN dropped during data bit 3 (line bit 3).
        write_a(8'hA5);
        s = cyc + 1;
        write_a(8'h00);
        write_a(8'hFF);
        walk(0, s, SeqA5, BitA, 3, "en");
        check_eq("en_txd_after", obs_txd(0), 1);
`ifdef UART_TX_FIFO_EN
        check_eq("en_busy_queued", obs_busy(0), 1);
`else
        check_eq("en_busy_nofifo", obs_busy(0), 0);
`endif
        repeat (1000) @(negedge clk);
        check_eq("en_txd_held", obs_txd(0), 1);
        bus_a.Tx_EN = 1'b1;
        s = cyc + 1;
`ifdef UART_TX_FIFO_EN
        walk(0, s, Seq00, BitA, -1, "en_q0");
        walk(0, s + Frame, SeqFF, BitA, -1, "en_q1");
        check_eq("en_q_busy_fall", obs_busy(0), 0);
`else
        repeat (600) @(negedge clk);
        check_eq("en_nofifo_no_frame", obs_txd(0), 1);
        check_eq("en_nofifo_busy", obs_busy(0), 0);
`endif

`ifdef UART_TX_FIFO_EN
        // Six writes into a depth-4 queue: five accepted, sixth dropped.
        @(negedge clk);
        s = cyc + 2;
        for (int k = 0; k < 6; k++) begin
            write_a(words[k]);
            check_eq($sformatf("fifo_full_w%0d", k), obs_full(0), 32'(exp_full[k]));
        end
        for (int k = 0; k < 5; k++) begin
            walk(0, s + k * Frame, seqs[k], BitA, -1, $sformatf("fifo_f%0d", k));
        end
        check_eq("fifo_busy_fall", obs_busy(0), 0);
        repeat (600) @(negedge clk);
        check_eq("fifo_no_sixth", obs_txd(0), 1);
`endif

        // Reset in the middle of a frame, with words queued if there is a queue.
        @(negedge clk);
        write_a(8'hA5);
        s = cyc + 1;
        write_a(8'h00);
        write_a(8'hFF);
        wait_until(s + 2 * BitA + 200);
        check_eq("mid_txd_low", obs_txd(0), 0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_txd", obs_txd(0), 1);
        check_eq("mid_rst_busy", obs_busy(0), 0);
        check_eq("mid_rst_full", obs_full(0), 0);
        check_eq("mid_rst_done", obs_done(0), 0);
        reset = 1'b0;
        repeat (600) @(negedge clk);
        check_eq("mid_after_txd", obs_txd(0), 1);
        check_eq("mid_after_busy", obs_busy(0), 0);
        check_eq("done_total_a", done_a, ExpDoneA);
        check_eq("done_total_b", done_b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
